// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the ADC capture controller.
// Holds the state encoding, default widths and the maximum frame depth.
package adc_cap_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OFS_W  = 10;
  localparam int unsigned DEF_DEPTH = 32'd1 << DEF_OFS_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_HOLDOFF,
    ST_WAIT_ACK
  } state_e;

  // Largest frame a bank of 2**ofs_w samples can hold.
  function automatic int unsigned depth_max(input int ofs_w);
    return 32'd1 << ofs_w;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Buffer write port and frame handshake between capture control and its consumer.
// master drives the writes and frame_ready; slave returns frame_ack.
interface adc_capture_ctrl_if
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFS_W  = DEF_OFS_W
);
  logic              buf_wr;
  logic [OFS_W:0]    buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              frame_ready;
  logic              frame_bank;
  logic [OFS_W:0]    frame_len;
  logic              frame_ack;

  modport master (
    output buf_wr, buf_addr, buf_data, frame_ready, frame_bank, frame_len,
    input  frame_ack
  );

  modport slave (
    input  buf_wr, buf_addr, buf_data, frame_ready, frame_bank, frame_len,
    output frame_ack
  );
endinterface

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger comparator on unsigned samples, purely combinational.
// Rising: prev below level and current at/above it; falling is the mirror image.
module adc_trig_detect
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] prev_i,
  input  logic [DATA_W-1:0] cur_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic              rise_i,
  output logic              hit_o
);
  assign hit_o = rise_i ? ((prev_i < level_i) && (cur_i >= level_i))
                        : ((prev_i > level_i) && (cur_i <= level_i));
endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC frame capture into a ping-pong buffer; one-cycle registered write latency.
// A completed frame waits in WAIT_ACK (samples dropped, overrun set) while the previous frame is unacknowledged.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFS_W  = DEF_OFS_W
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_data_valid,
  input  logic              cfg_trig_en,
  input  logic              cfg_trig_rise,
  input  logic [DATA_W-1:0] cfg_trig_level,
  input  logic [OFS_W:0]    cfg_depth,
  input  logic [31:0]       cfg_holdoff,
  adc_capture_ctrl_if.master bus,
  output logic              busy,
  output logic              overrun
);
  localparam logic [OFS_W:0] MAX_DEPTH = (OFS_W+1)'(depth_max(OFS_W));

  state_e            state_q, state_d;
  logic [OFS_W-1:0]  offset_q, offset_d;
  logic              bank_q, bank_d;
  logic [31:0]       hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              buf_wr_q, buf_wr_d;
  logic [OFS_W:0]    buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              frame_ready_q, frame_ready_d;
  logic              frame_bank_q, frame_bank_d;
  logic [OFS_W:0]    frame_len_q, frame_len_d;
  logic              overrun_q, overrun_d;
  logic              trig_en_q, trig_en_d;
  logic              rise_q, rise_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [OFS_W:0]    depth_q, depth_d;
  logic [31:0]       holdoff_q, holdoff_d;

  logic trig_hit, ack_acc, last, accept, present, latch_cfg;

  adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .prev_i  (prev_q),
    .cur_i   (adc_data),
    .level_i (level_q),
    .rise_i  (rise_q),
    .hit_o   (trig_hit)
  );

  assign ack_acc = bus.frame_ack && frame_ready_q;
  assign last    = ({1'b0, offset_q} == (depth_q - (OFS_W+1)'(1)));

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    bank_d        = bank_q;
    hold_cnt_d    = hold_cnt_q;
    prev_d        = adc_data_valid ? adc_data : prev_q;
    buf_wr_d      = 1'b0;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    frame_ready_d = frame_ready_q && !ack_acc;
    frame_bank_d  = frame_bank_q;
    frame_len_d   = frame_len_q;
    overrun_d     = overrun_q;
    trig_en_d     = trig_en_q;
    rise_d        = rise_q;
    level_d       = level_q;
    depth_d       = depth_q;
    holdoff_d     = holdoff_q;
    accept        = 1'b0;
    present       = 1'b0;
    latch_cfg     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d   = ST_ARM;
        latch_cfg = 1'b1;
      end
      ST_ARM:     accept = adc_data_valid && (!trig_en_q || trig_hit);
      ST_CAPTURE: accept = adc_data_valid;
      ST_HOLDOFF: begin
        if (hold_cnt_q >= holdoff_q) begin
          state_d   = ST_ARM;
          latch_cfg = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      ST_WAIT_ACK: present = ack_acc;
      default:     state_d = ST_IDLE;
    endcase

    if (accept) begin
      buf_wr_d   = 1'b1;
      buf_data_d = adc_data;
      buf_addr_d = {bank_q, offset_q};
      if (last) begin
        offset_d = '0;
        // An ack landing on the completion edge frees the old frame in time.
        if (!frame_ready_q || ack_acc) begin
          present = 1'b1;
        end else begin
          state_d   = ST_WAIT_ACK;
          overrun_d = 1'b1;
        end
      end else begin
        offset_d = offset_q + OFS_W'(1);
        state_d  = ST_CAPTURE;
      end
    end

    if (present) begin
      frame_ready_d = 1'b1;
      frame_bank_d  = bank_q;
      frame_len_d   = depth_q;
      bank_d        = !bank_q;
      hold_cnt_d    = '0;
      state_d       = ST_HOLDOFF;
    end

    if (latch_cfg) begin
      trig_en_d = cfg_trig_en;
      rise_d    = cfg_trig_rise;
      level_d   = cfg_trig_level;
      depth_d   = ((cfg_depth == '0) || (cfg_depth > MAX_DEPTH)) ? MAX_DEPTH : cfg_depth;
      holdoff_d = cfg_holdoff;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      offset_q      <= '0;
      bank_q        <= 1'b0;
      hold_cnt_q    <= '0;
      prev_q        <= '0;
      buf_wr_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      frame_len_q   <= '0;
      overrun_q     <= 1'b0;
      trig_en_q     <= 1'b0;
      rise_q        <= 1'b0;
      level_q       <= '0;
      depth_q       <= MAX_DEPTH;
      holdoff_q     <= '0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      bank_q        <= bank_d;
      hold_cnt_q    <= hold_cnt_d;
      prev_q        <= prev_d;
      buf_wr_q      <= buf_wr_d;
      buf_addr_q    <= buf_addr_d;
      buf_data_q    <= buf_data_d;
      frame_ready_q <= frame_ready_d;
      frame_bank_q  <= frame_bank_d;
      frame_len_q   <= frame_len_d;
      overrun_q     <= overrun_d;
      trig_en_q     <= trig_en_d;
      rise_q        <= rise_d;
      level_q       <= level_d;
      depth_q       <= depth_d;
      holdoff_q     <= holdoff_d;
    end
  end

  assign bus.buf_wr      = buf_wr_q;
  assign bus.buf_addr    = buf_addr_q;
  assign bus.buf_data    = buf_data_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.frame_bank  = frame_bank_q;
  assign bus.frame_len   = frame_len_q;
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_ARM);
  assign overrun         = overrun_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: reset, free-run, triggers, gaps, overrun, mid-frame reset, depth 0.
module tb_adc_capture_ctrl;
  logic        adc_clk;
  logic        rst_n;
  logic [7:0]  adc_data;
  logic        adc_data_valid;
  logic        cfg_trig_en;
  logic        cfg_trig_rise;
  logic [7:0]  cfg_trig_level;
  logic [10:0] cfg_depth;
  logic [31:0] cfg_holdoff;
  logic        busy;
  logic        overrun;

  int n_pass  = 0;
  int n_total = 0;

  adc_capture_ctrl_if #(.DATA_W(8), .OFS_W(10)) bus ();

  adc_capture_ctrl #(.DATA_W(8), .OFS_W(10)) dut (
    .adc_clk        (adc_clk),
    .rst_n          (rst_n),
    .adc_data       (adc_data),
    .adc_data_valid (adc_data_valid),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_trig_rise  (cfg_trig_rise),
    .cfg_trig_level (cfg_trig_level),
    .cfg_depth      (cfg_depth),
    .cfg_holdoff    (cfg_holdoff),
    .bus            (bus),
    .busy           (busy),
    .overrun        (overrun)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, ".wr"}, 32'(bus.buf_wr), 32'd1);
    chk({tag, ".addr"}, 32'(bus.buf_addr), addr);
    chk({tag, ".data"}, 32'(bus.buf_data), data);
  endtask

  task automatic start(input logic en, input logic rise, input logic [7:0] lvl,
                       input logic [10:0] depth, input logic [31:0] hold);
    cfg_trig_en    = en;
    cfg_trig_rise  = rise;
    cfg_trig_level = lvl;
    cfg_depth      = depth;
    cfg_holdoff    = hold;
    adc_data_valid = 1'b0;
    bus.frame_ack  = 1'b0;
    rst_n          = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; adc_data = '0; adc_data_valid = 1'b0; bus.frame_ack = 1'b0;
    cfg_trig_en = 1'b0; cfg_trig_rise = 1'b1; cfg_trig_level = '0;
    cfg_depth = 11'd4; cfg_holdoff = '0;
    tick();
    tick();
    chk("rst.buf_wr", 32'(bus.buf_wr), 32'd0);
    chk("rst.buf_addr", 32'(bus.buf_addr), 32'd0);
    chk("rst.buf_data", 32'(bus.buf_data), 32'd0);
    chk("rst.frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("rst.frame_len", 32'(bus.frame_len), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    // Free-run, depth 4: data 10..13 to bank 0 offsets 0..3.
    start(1'b0, 1'b1, 8'h00, 11'd4, 32'd0);
    adc_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adc_data = 8'(10 + i);
      tick();
      chk_wr("free", 32'(i), 32'(10 + i));
    end
    chk("free.frame_ready", 32'(bus.frame_ready), 32'd1);
    chk("free.frame_bank", 32'(bus.frame_bank), 32'd0);
    chk("free.frame_len", 32'(bus.frame_len), 32'd4);
    chk("free.busy", 32'(busy), 32'd1);
    adc_data_valid = 1'b0;
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("free.ack_drop", 32'(bus.frame_ready), 32'd0);
    chk("free.idle_wr", 32'(bus.buf_wr), 32'd0);

    // Rising trigger at 0x80 on a ramp.
    start(1'b1, 1'b1, 8'h80, 11'd4, 32'd0);
    adc_data_valid = 1'b1;
    adc_data = 8'h70; tick(); chk("rise.pre0", 32'(bus.buf_wr), 32'd0);
    adc_data = 8'h78; tick(); chk("rise.pre1", 32'(bus.buf_wr), 32'd0);
    adc_data = 8'h80; tick(); chk_wr("rise.first", 32'd0, 32'h80);
    adc_data = 8'h88; tick(); chk_wr("rise.second", 32'd1, 32'h88);
    adc_data = 8'h90; tick(); chk_wr("rise.third", 32'd2, 32'h90);

    // Falling trigger at 0x40; the upward crossing must not fire.
    start(1'b1, 1'b0, 8'h40, 11'd4, 32'd0);
    adc_data_valid = 1'b1;
    adc_data = 8'h30; tick(); chk("fall.pre0", 32'(bus.buf_wr), 32'd0);
    adc_data = 8'h50; tick(); chk("fall.up", 32'(bus.buf_wr), 32'd0);
    adc_data = 8'h48; tick(); chk("fall.pre2", 32'(bus.buf_wr), 32'd0);
    adc_data = 8'h40; tick(); chk_wr("fall.first", 32'd0, 32'h40);

    // Gappy valid during the same capture keeps offsets contiguous.
    adc_data_valid = 1'b0; tick(); chk("gap.0", 32'(bus.buf_wr), 32'd0);
    adc_data_valid = 1'b1; adc_data = 8'h41; tick(); chk_wr("gap.1", 32'd1, 32'h41);
    adc_data_valid = 1'b0; tick(); chk("gap.2", 32'(bus.buf_wr), 32'd0);
    adc_data_valid = 1'b1; adc_data = 8'h42; tick(); chk_wr("gap.3", 32'd2, 32'h42);
    adc_data = 8'h43; tick(); chk_wr("gap.4", 32'd3, 32'h43);
    chk("gap.frame_ready", 32'(bus.frame_ready), 32'd1);

    // Two frames, holdoff 2, no ack: second frame stalls in WAIT_ACK.
    start(1'b0, 1'b1, 8'h00, 11'd4, 32'd2);
    adc_data_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      adc_data = 8'(8'hA0 + i);
      tick();
      if (i < 4) chk_wr("ovr.f0", 32'(i), 32'(8'hA0 + i));
      else if (i < 7) chk("ovr.hold", 32'(bus.buf_wr), 32'd0);
      else chk_wr("ovr.f1", 32'(1024 + i - 7), 32'(8'hA0 + i));
      if (i == 3) chk("ovr.no_ovr_yet", 32'(overrun), 32'd0);
    end
    chk("ovr.overrun", 32'(overrun), 32'd1);
    chk("ovr.old_bank", 32'(bus.frame_bank), 32'd0);
    chk("ovr.busy", 32'(busy), 32'd1);
    adc_data = 8'hFF; tick();
    chk("ovr.drop", 32'(bus.buf_wr), 32'd0);
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    chk("ovr.ready", 32'(bus.frame_ready), 32'd1);
    chk("ovr.new_bank", 32'(bus.frame_bank), 32'd1);
    chk("ovr.len", 32'(bus.frame_len), 32'd4);
    chk("ovr.sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a depth-8 frame.
    start(1'b0, 1'b1, 8'h00, 11'd8, 32'd0);
    adc_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_data = 8'(1 + i);
      tick();
      chk_wr("mid.pre", 32'(i), 32'(1 + i));
    end
    rst_n = 1'b0;
    tick();
    chk("mid.wr", 32'(bus.buf_wr), 32'd0);
    chk("mid.addr", 32'(bus.buf_addr), 32'd0);
    chk("mid.data", 32'(bus.buf_data), 32'd0);
    chk("mid.ready", 32'(bus.frame_ready), 32'd0);
    chk("mid.bank", 32'(bus.frame_bank), 32'd0);
    chk("mid.len", 32'(bus.frame_len), 32'd0);
    chk("mid.overrun", 32'(overrun), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    cfg_depth = 11'd4;
    adc_data_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    adc_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adc_data = 8'(8'h20 + i);
      tick();
      chk_wr("mid.next", 32'(i), 32'(8'h20 + i));
    end
    chk("mid.next_ready", 32'(bus.frame_ready), 32'd1);
    chk("mid.next_bank", 32'(bus.frame_bank), 32'd0);

    // Ack on the completion edge frees the old frame: no overrun.
    start(1'b0, 1'b1, 8'h00, 11'd2, 32'd0);
    adc_data_valid = 1'b1;
    adc_data = 8'd1; tick(); chk_wr("same.g1", 32'd0, 32'd1);
    adc_data = 8'd2; tick(); chk_wr("same.g2", 32'd1, 32'd2);
    adc_data = 8'd3; tick(); chk("same.hold", 32'(bus.buf_wr), 32'd0);
    adc_data = 8'd4; tick(); chk_wr("same.g4", 32'd1024, 32'd4);
    bus.frame_ack = 1'b1;
    adc_data = 8'd5; tick(); chk_wr("same.g5", 32'd1025, 32'd5);
    bus.frame_ack = 1'b0;
    chk("same.ready", 32'(bus.frame_ready), 32'd1);
    chk("same.bank", 32'(bus.frame_bank), 32'd1);
    chk("same.overrun", 32'(overrun), 32'd0);

    // Depth 0 is treated as a full 1024-sample bank.
    start(1'b0, 1'b1, 8'h00, 11'd0, 32'd0);
    adc_data_valid = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      adc_data = 8'(i);
      tick();
    end
    chk("d0.addr1022", 32'(bus.buf_addr), 32'd1022);
    chk("d0.not_ready", 32'(bus.frame_ready), 32'd0);
    adc_data = 8'hFF;
    tick();
    chk_wr("d0.last", 32'd1023, 32'hFF);
    chk("d0.ready", 32'(bus.frame_ready), 32'd1);
    chk("d0.len", 32'(bus.frame_len), 32'd1024);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
